// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button synchroniser and debouncer with rise/fall/repeat pulses
// Optional auto-repeat output is enabled by defining DEBOUNCE_REPEAT_EN.
module button_debouncer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 250,
   parameter int REP_W         = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic btn_repeat
);

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_RISE_CHK = 2'd1,
      ST_HIGH     = 2'd2,
      ST_FALL_CHK = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic       sync1_q;
   logic       sync2_q;
   logic       s;
   state_t     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic       level_q;
   logic       rise_q;
   logic       fall_q;

   // Two-flop synchroniser; only the second flop feeds the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;

   // Stable-count FSM; a change is accepted only after STABLE_CYCLES equal samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            ST_LOW: begin
               if (s) begin
                  if (STABLE_CYCLES == 1) begin
                     state_q <= ST_HIGH;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                     rise_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RISE_CHK;
                     cnt_q   <= CNT_ONE;
                  end
               end
            end
            ST_RISE_CHK: begin
               if (!s) begin
                  state_q <= ST_LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= ST_HIGH;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (!s) begin
                  if (STABLE_CYCLES == 1) begin
                     state_q <= ST_LOW;
                     cnt_q   <= '0;
                     level_q <= 1'b0;
                     fall_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FALL_CHK;
                     cnt_q   <= CNT_ONE;
                  end
               end
            end
            ST_FALL_CHK: begin
               if (s) begin
                  state_q <= ST_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= ST_LOW;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
                  fall_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_LOW;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;
   assign btn_fall  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
   localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REPEAT_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_ONE        = REP_W'(1);

   logic [REP_W-1:0] rep_q;
   logic             rep_arm_q;
   logic             repeat_q;

   // Auto-repeat timer: runs while accepted-high, frozen during a release check so an
   // aborted release resumes the schedule; rep_arm_q selects initial delay vs period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_q     <= '0;
         rep_arm_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         repeat_q <= 1'b0;
         case (state_q)
            ST_HIGH: begin
               if (s) begin
                  if ((!rep_arm_q && rep_q == REP_FIRST_LAST) ||
                      (rep_arm_q && rep_q == REP_NEXT_LAST)) begin
                     repeat_q  <= 1'b1;
                     rep_q     <= '0;
                     rep_arm_q <= 1'b1;
                  end else begin
                     rep_q <= rep_q + REP_ONE;
                  end
               end
            end
            ST_FALL_CHK: begin
               rep_q     <= rep_q;
               rep_arm_q <= rep_arm_q;
            end
            default: begin
               rep_q     <= '0;
               rep_arm_q <= 1'b0;
            end
         endcase
      end
   end

   assign btn_repeat = repeat_q;
`else
   assign btn_repeat = 1'b0;
`endif

endmodule
